// File: rtl/color_region_tracker_if.sv
// -----------------------------------------------------------------------------
// color_region_tracker_if
// Pixel stream bundle feeding the colour region tracker.
//   pix_valid : x/y/eh_verde carry a pixel this cycle
//   x, y      : pixel column / row (10 bits each)
//   eh_verde  : pixel matches the tracked colour
// master drives the stream (video source), slave consumes it (tracker).
// -----------------------------------------------------------------------------
interface color_region_tracker_if;
    logic       pix_valid;
    logic [9:0] x;
    logic [9:0] y;
    logic       eh_verde;

    modport master (output pix_valid, x, y, eh_verde);
    modport slave  (input  pix_valid, x, y, eh_verde);
endinterface

// File: rtl/color_region_tracker.sv
// -----------------------------------------------------------------------------
// color_region_tracker
// Counts colour-matching pixels in NUM_REGIONS equal-width vertical strips of
// each frame, then flags strips whose count exceeds a threshold and reports
// the strip with the highest count.
//
// Ports
//   clk          : single clock, rising edge
//   reset_n      : asynchronous active-low reset
//   enable       : low = synchronous clear back to IDLE
//   pix          : pixel stream (color_region_tracker_if.slave)
//   threshold    : detection limit, latched at frame start
//   region_hit   : per-strip detected flags, held until the next publish
//   best_region  : strip with the highest count (0 when best_valid is low)
//   best_valid   : at least one region_hit bit set
//   frame_done   : one-cycle pulse while freshly published outputs appear
//   overrun      : sticky, a frame start arrived while resolving/publishing
//
// Build option
//   COLOR_TRACKER_DEBOUNCE_EN : region_hit bits change only after two
//   consecutive frames agree; best_region/best_valid follow the debounced
//   flags.
// -----------------------------------------------------------------------------
module color_region_tracker #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int NUM_REGIONS = 4,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    color_region_tracker_if.slave  pix,
    input  logic [CNT_W-1:0]       threshold,
    output logic [NUM_REGIONS-1:0] region_hit,
    output logic [2:0]             best_region,
    output logic                   best_valid,
    output logic                   frame_done,
    output logic                   overrun
);
    localparam int         SEG  = WIDTH / NUM_REGIONS;
    localparam logic [2:0] LAST = 3'(NUM_REGIONS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, PUBLISH} state_t;
    state_t state, state_next;

    logic [CNT_W-1:0]       cnt [NUM_REGIONS];
    logic [CNT_W-1:0]       thr;
    logic [2:0]             ridx;
    logic [CNT_W-1:0]       max_cnt;
    logic [2:0]             best_idx;
    logic                   found;
    logic [NUM_REGIONS-1:0] flag_acc;
`ifdef COLOR_TRACKER_DEBOUNCE_EN
    logic [NUM_REGIONS-1:0] raw_acc;
    logic [NUM_REGIONS-1:0] prev_raw;
    logic [NUM_REGIONS-1:0] raw_nx;
    logic                   prev_b;
    logic                   held_b;
`endif

    logic                   frame_start;
    logic                   frame_end;
    logic [NUM_REGIONS-1:0] inc;
    logic [CNT_W-1:0]       cur;
    logic                   raw;
    logic                   flag;
    logic                   take;
    logic                   found_nx;
    logic [CNT_W-1:0]       max_nx;
    logic [2:0]             best_nx;
    logic [NUM_REGIONS-1:0] flag_nx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign frame_start = pix.pix_valid && (pix.x == 10'd0) && (pix.y == 10'd0);
    assign frame_end   = pix.pix_valid && (pix.x == 10'(WIDTH - 1)) &&
                         (pix.y == 10'(HEIGHT - 1));

    // One-hot strip select for the current matching pixel.
    always_comb begin
        inc = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (pix.pix_valid && pix.eh_verde && (int'(pix.x) < WIDTH) &&
                (int'(pix.x) / SEG == i))
                inc[i] = 1'b1;
        end
    end

    // Resolve step for strip ridx: threshold compare and running maximum.
    // Only flagged strips compete, so a strip without a flag never becomes best.
    always_comb begin
        cur     = '0;
        flag_nx = flag_acc;
`ifdef COLOR_TRACKER_DEBOUNCE_EN
        prev_b  = 1'b0;
        held_b  = 1'b0;
        raw_nx  = raw_acc;
`endif
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (ridx == 3'(i)) begin
                cur = cnt[i];
`ifdef COLOR_TRACKER_DEBOUNCE_EN
                prev_b = prev_raw[i];
                held_b = region_hit[i];
`endif
            end
        end
        raw = cur > thr;
`ifdef COLOR_TRACKER_DEBOUNCE_EN
        // Two agreeing frames move the flag; a disagreement holds it.
        flag = (raw == prev_b) ? raw : held_b;
`else
        flag = raw;
`endif
        take     = flag && (!found || (cur > max_cnt));
        found_nx = found || flag;
        max_nx   = take ? cur : max_cnt;
        best_nx  = take ? ridx : best_idx;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (ridx == 3'(i)) begin
                flag_nx[i] = flag;
`ifdef COLOR_TRACKER_DEBOUNCE_EN
                raw_nx[i] = raw;
`endif
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = ACCUM;
            ACCUM:   if (frame_end)   state_next = RESOLVE;
            RESOLVE: if (ridx == LAST) state_next = PUBLISH;
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            for (int i = 0; i < NUM_REGIONS; i++) cnt[i] <= '0;
            thr         <= '0;
            ridx        <= '0;
            max_cnt     <= '0;
            best_idx    <= '0;
            found       <= 1'b0;
            flag_acc    <= '0;
            region_hit  <= '0;
            best_region <= '0;
            best_valid  <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
`ifdef COLOR_TRACKER_DEBOUNCE_EN
            raw_acc     <= '0;
            prev_raw    <= '0;
`endif
        end else if (!enable) begin
            state       <= IDLE;
            for (int i = 0; i < NUM_REGIONS; i++) cnt[i] <= '0;
            thr         <= '0;
            ridx        <= '0;
            max_cnt     <= '0;
            best_idx    <= '0;
            found       <= 1'b0;
            flag_acc    <= '0;
            region_hit  <= '0;
            best_region <= '0;
            best_valid  <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
`ifdef COLOR_TRACKER_DEBOUNCE_EN
            raw_acc     <= '0;
            prev_raw    <= '0;
`endif
        end else begin
            state      <= state_next;
            frame_done <= 1'b0;
            case (state)
                IDLE, ACCUM: begin
                    // A frame start (first or restart) clears and counts its own pixel.
                    if (frame_start) begin
                        thr <= threshold;
                        for (int i = 0; i < NUM_REGIONS; i++)
                            cnt[i] <= inc[i] ? CNT_W'(1) : '0;
                    end else if (state == ACCUM) begin
                        for (int i = 0; i < NUM_REGIONS; i++)
                            if (inc[i]) cnt[i] <= sat_inc(cnt[i]);
                    end
                    ridx     <= '0;
                    max_cnt  <= '0;
                    best_idx <= '0;
                    found    <= 1'b0;
                    flag_acc <= '0;
`ifdef COLOR_TRACKER_DEBOUNCE_EN
                    raw_acc  <= '0;
`endif
                end
                RESOLVE: begin
                    ridx     <= ridx + 3'd1;
                    max_cnt  <= max_nx;
                    best_idx <= best_nx;
                    found    <= found_nx;
                    flag_acc <= flag_nx;
`ifdef COLOR_TRACKER_DEBOUNCE_EN
                    raw_acc  <= raw_nx;
`endif
                    if (frame_start) overrun <= 1'b1;
                    // Results land together with the pulse in the PUBLISH cycle.
                    if (ridx == LAST) begin
                        region_hit  <= flag_nx;
                        best_valid  <= found_nx;
                        best_region <= found_nx ? best_nx : 3'd0;
                        frame_done  <= 1'b1;
`ifdef COLOR_TRACKER_DEBOUNCE_EN
                        prev_raw    <= raw_nx;
`endif
                    end
                end
                PUBLISH: begin
                    if (frame_start) overrun <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_color_region_tracker.sv
`timescale 1ns/1ps
module tb_color_region_tracker;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] threshold;
    logic [3:0]  region_hit;
    logic [2:0]  best_region;
    logic        best_valid;
    logic        frame_done;
    logic        overrun;

    color_region_tracker_if pif ();

    color_region_tracker #(
        .WIDTH(640), .HEIGHT(480), .NUM_REGIONS(4), .CNT_W(16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .pix         (pif),
        .threshold   (threshold),
        .region_hit  (region_hit),
        .best_region (best_region),
        .best_valid  (best_valid),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] hit;
        logic [2:0] best;
        logic       bv;
        logic       ov;
        int         at;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor: every frame_done pulse consumes one expected result.
    always @(negedge clk) begin
        if (reset_n && frame_done) begin
            if (q.size() == 0) begin
                check("unexpected_frame_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("region_hit",  int'(region_hit),  int'(e.hit));
                check("best_region", int'(best_region), int'(e.best));
                check("best_valid",  int'(best_valid),  int'(e.bv));
                check("overrun",     int'(overrun),     int'(e.ov));
                check("done_cycle",  cyc,               e.at);
            end
        end
    end

    task automatic px(input int xx, input int yy, input logic g);
        @(negedge clk);
        pif.pix_valid = 1'b1;
        pif.x         = 10'(xx);
        pif.y         = 10'(yy);
        pif.eh_verde  = g;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pif.pix_valid = 1'b0;
            pif.eh_verde  = 1'b0;
        end
    endtask

    task automatic run(input int x0, input int n, input int yy);
        for (int k = 0; k < n; k++) px(x0 + k, yy, 1'b1);
    endtask

    // Called in the cycle the frame-end pixel is driven.
    task automatic expect_done(input logic [3:0] h, input int b, input logic bv, input logic ov);
        exp_t e;
        e.hit  = h;
        e.best = 3'(b);
        e.bv   = bv;
        e.ov   = ov;
        e.at   = cyc + 5;
        q.push_back(e);
    endtask

`ifdef COLOR_TRACKER_DEBOUNCE_EN
    logic [3:0] dh [5] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    int         db [5] = '{0, 2, 2, 2, 0};
    logic       dv [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`endif

    initial begin
        pif.pix_valid = 1'b0;
        pif.x         = '0;
        pif.y         = '0;
        pif.eh_verde  = 1'b0;
        threshold     = 16'd10;
        repeat (3) @(negedge clk);
        check("rst_region_hit",  int'(region_hit),  0);
        check("rst_best_region", int'(best_region), 0);
        check("rst_best_valid",  int'(best_valid),  0);
        check("rst_frame_done",  int'(frame_done),  0);
        check("rst_overrun",     int'(overrun),     0);
        reset_n = 1'b1;
        enable  = 1'b1;
        idle(2);

`ifdef COLOR_TRACKER_DEBOUNCE_EN
        for (int f = 0; f < 5; f++) begin
            px(0, 0, 1'b0);
            if (f < 3) run(320, 30, 4);
            px(639, 479, 1'b0);
            expect_done(dh[f], db[f], dv[f], 1'b0);
            idle(8);
        end
`else
        // 11 matches in strip 1.
        px(0, 0, 1'b0);
        run(160, 11, 10);
        px(639, 479, 1'b0);
        expect_done(4'b0010, 1, 1'b1, 1'b0);
        idle(8);
        idle(10);
        check("hold_region_hit", int'(region_hit), 2);
        check("hold_best_valid", int'(best_valid), 1);

        // Exactly threshold matches: not a hit.
        px(0, 0, 1'b0);
        run(480, 10, 3);
        px(639, 479, 1'b0);
        expect_done(4'b0000, 0, 1'b0, 1'b0);
        idle(8);

        // Two strips with equal counts.
        px(0, 0, 1'b0);
        run(0, 20, 1);
        run(320, 20, 1);
        px(639, 479, 1'b0);
        expect_done(4'b0101, 0, 1'b1, 1'b0);
        idle(8);

        // Counted start pixel, strip edges, tie, threshold latched at start.
        px(0, 0, 1'b1);
        px(150, 2, 1'b1);
        threshold = 16'd0;
        run(151, 9, 2);
        run(629, 11, 2);
        px(200, 2, 1'b1);
        px(639, 479, 1'b0);
        expect_done(4'b1001, 0, 1'b1, 1'b0);
        threshold = 16'd10;
        idle(8);

        // Restart mid-frame discards earlier counts.
        px(0, 0, 1'b0);
        run(320, 15, 5);
        px(0, 0, 1'b0);
        run(170, 11, 5);
        px(639, 479, 1'b0);
        expect_done(4'b0010, 1, 1'b1, 1'b0);
        idle(8);

        // Frame start two cycles after frame end is dropped.
        px(0, 0, 1'b0);
        run(480, 12, 7);
        px(639, 479, 1'b0);
        expect_done(4'b1000, 3, 1'b1, 1'b1);
        idle(1);
        px(0, 0, 1'b0);
        run(0, 20, 7);
        px(639, 479, 1'b0);
        idle(12);
        check("overrun_sticky", int'(overrun), 1);
        check("dropped_hold",   int'(region_hit), 8);

        // enable low clears outputs and overrun.
        @(negedge clk);
        pif.pix_valid = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("en_overrun",     int'(overrun),     0);
        check("en_region_hit",  int'(region_hit),  0);
        check("en_best_valid",  int'(best_valid),  0);
        check("en_best_region", int'(best_region), 0);
        enable = 1'b1;

        // enable low mid-frame: rest of that frame must not publish.
        px(0, 0, 1'b0);
        run(160, 20, 9);
        @(negedge clk);
        pif.pix_valid = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        run(160, 11, 9);
        px(639, 479, 1'b0);
        idle(12);

        // Reset mid-frame, then an empty frame.
        px(0, 0, 1'b0);
        run(160, 50, 11);
        @(negedge clk);
        pif.pix_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_frame_done", int'(frame_done), 0);
        check("mid_rst_overrun",    int'(overrun),    0);
        reset_n = 1'b1;
        px(0, 0, 1'b0);
        px(639, 479, 1'b0);
        expect_done(4'b0000, 0, 1'b0, 1'b0);
        idle(8);
`endif

        begin
            int t;
            t = 0;
            while (q.size() != 0 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (q.size() != 0) check("missing_frame_done", q.size(), 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
